opc_tx: RTL and testbench

//  Output-port transmitter that feeds a downstream input port controller.

---
 rtl/opc_tx_pkg.sv | 39 +++
 rtl/opc_tx_vc_credit_ctr.sv | 40 ++++
 rtl/opc_tx.sv | 104 ++++++++++
 tb/tb_opc_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opc_tx_pkg.sv
// Shared constants, types and the round-robin pick for the output-port
// transmitter. OPC_TX_CREDIT_BYPASS_EN is consumed by opc_tx.sv.
package opc_tx_pkg;

  localparam int NUM_VC         = 4;
  localparam int VC_INDEX_WIDTH = 3;
  localparam int VC_W           = VC_INDEX_WIDTH - 1;
  localparam int IR_DATA_WIDTH  = 32;
  localparam int PPV_POS        = 27;
  localparam int PPV_W          = 5;
  localparam int NUM_PORT       = 5;
  localparam int VC_DEPTH       = 4;
  localparam int CRED_W         = $clog2(VC_DEPTH + 1);

  typedef logic [VC_W-1:0]          vc_t;
  typedef logic [IR_DATA_WIDTH-1:0] flit_t;

  // First requesting VC at or after ptr; NUM_VC is a power of two so
  // the index wraps on its own.
  function automatic vc_t rr_pick(
    input logic [NUM_VC-1:0] req,
    input vc_t               ptr
  );
    vc_t  g;
    vc_t  c;
    logic hit;
    g   = ptr;
    hit = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      c = ptr + vc_t'(i);
      if (!hit && req[c]) begin
        g   = c;
        hit = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/opc_tx_vc_credit_ctr.sv
// Per-VC credit counter: starts full, saturates at VC_DEPTH and flags a
// return that arrives while full.
module vc_credit_ctr
  import opc_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [CRED_W-1:0] cnt,
  output logic              nz,
  output logic              ovf
);

  localparam logic [CRED_W-1:0] FULL = CRED_W'(VC_DEPTH);

  logic [CRED_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unique case ({inc, dec})
      2'b10: begin
        if (cnt_q == FULL) ovf = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= FULL;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign nz  = (cnt_q != '0);

endmodule

// File: rtl/opc_tx.sv
// Output-port transmitter: one-flit hold, round-robin VC pick, per-VC credits.
// Define OPC_TX_CREDIT_BYPASS_EN to let a same-cycle credit return be spent.
module opc_tx
  import opc_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  flit_t             in_data,
  output logic              in_ready,
  input  logic [NUM_VC-1:0] credit_ret,
  output flit_t             data_out,
  output vc_t               vc_out,
  output logic              valid_out,
  output logic [NUM_VC-1:0] vc_avail,
  output logic              err_credit
);

  flit_t hold_q, hold_d;
  logic  hold_v_q, hold_v_d;
  vc_t   ptr_q, ptr_d;
  flit_t dout_q, dout_d;
  vc_t   vc_q, vc_d;
  logic  vld_q, vld_d;
  logic  err_q, err_d;

  logic [NUM_VC-1:0] nz, ovf, dec, elig;
  logic [CRED_W-1:0] cnt [NUM_VC];
  logic              launch, accept, is_null;
  vc_t               grant;

`ifdef OPC_TX_CREDIT_BYPASS_EN
  assign elig = nz | credit_ret;
`else
  assign elig = nz;
`endif

  assign launch   = hold_v_q & (|elig);
  assign grant    = rr_pick(elig, ptr_q);
  assign in_ready = ~hold_v_q | launch;
  assign accept   = in_valid & in_ready;
  assign is_null  = (in_data[PPV_POS +: PPV_W] == '0);

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    assign dec[g]      = launch & (grant == vc_t'(g));
    assign vc_avail[g] = (cnt[g] != '0);
    vc_credit_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (credit_ret[g]),
      .dec (dec[g]),
      .cnt (cnt[g]),
      .nz  (nz[g]),
      .ovf (ovf[g])
    );
  end

  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q & ~launch;
    ptr_d    = ptr_q;
    dout_d   = '0;
    vc_d     = vc_q;
    vld_d    = 1'b0;
    err_d    = err_q | (|ovf);
    // Null flits are consumed here and never reach the link.
    if (accept) begin
      hold_d   = in_data;
      hold_v_d = ~is_null;
    end
    if (launch) begin
      ptr_d  = grant + vc_t'(1);
      dout_d = hold_q;
      vc_d   = grant;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      ptr_q    <= '0;
      dout_q   <= '0;
      vc_q     <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      ptr_q    <= ptr_d;
      dout_q   <= dout_d;
      vc_q     <= vc_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign data_out   = dout_q;
  assign vc_out     = vc_q;
  assign valid_out  = vld_q;
  assign err_credit = err_q;

endmodule

// File: tb/tb_opc_tx.sv
// Self-checking bench for opc_tx: vector table, directed corner cases and
// random traffic against a credit/queue reference model.
module tb_opc_tx;
  import opc_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  flit_t      in_data;
  logic       in_ready;
  logic [3:0] credit_ret;
  flit_t      data_out;
  vc_t        vc_out;
  logic       valid_out;
  logic [3:0] vc_avail;
  logic       err_credit;

  always #5 clk = ~clk;

  opc_tx u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .credit_ret (credit_ret),
    .data_out   (data_out),
    .vc_out     (vc_out),
    .valid_out  (valid_out),
    .vc_avail   (vc_avail),
    .err_credit (err_credit)
  );

  int checks   = 0;
  int failures = 0;

  bit    m_hv;
  flit_t m_hold;
  int    m_cred [4];
  int    m_ptr;
  bit    m_err;
  int    m_vc;
  int    nlaunch;
  bit    last_rdy;

  typedef struct {
    bit         iv;
    flit_t      d;
    logic [3:0] ret;
    bit         e_rdy;
    bit         e_vld;
    int         e_vc;
    flit_t      e_dat;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic flit_t mk(input logic [4:0] ppv, input int n);
    flit_t f;
    f = flit_t'(n);
    f[PPV_POS +: PPV_W] = ppv;
    return f;
  endfunction

  task automatic m_reset();
    m_hv   = 1'b0;
    m_hold = '0;
    for (int i = 0; i < 4; i++) m_cred[i] = VC_DEPTH;
    m_ptr = 0;
    m_err = 1'b0;
    m_vc  = 0;
  endtask

  function automatic bit elig(input int v, input logic [3:0] r);
`ifdef OPC_TX_CREDIT_BYPASS_EN
    return (m_cred[v] > 0) || r[v];
`else
    return (m_cred[v] > 0);
`endif
  endfunction

  task automatic cyc(input bit iv, input flit_t id, input logic [3:0] ir);
    bit         launch;
    bit         rdy;
    int         g;
    logic [3:0] avail;
    @(negedge clk);
    in_valid   = iv;
    in_data    = id;
    credit_ret = ir;
    #1;
    launch = 1'b0;
    g      = 0;
    if (m_hv) begin
      for (int k = 0; k < 4; k++) begin
        if (!launch && elig((m_ptr + k) % 4, ir)) begin
          launch = 1'b1;
          g      = (m_ptr + k) % 4;
        end
      end
    end
    rdy = !m_hv || launch;
    for (int i = 0; i < 4; i++) avail[i] = (m_cred[i] > 0);
    last_rdy = in_ready;
    chk("in_ready", in_ready, rdy);
    chk("vc_avail", vc_avail, avail);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_cred[i] = m_cred[i] + int'(ir[i]) - ((launch && g == i) ? 1 : 0);
      if (m_cred[i] > VC_DEPTH) begin
        m_cred[i] = VC_DEPTH;
        m_err     = 1'b1;
      end
    end
    if (launch) begin
      m_ptr = (g + 1) % 4;
      m_vc  = g;
      nlaunch++;
    end
    chk("valid_out", valid_out, launch);
    chk("data_out", data_out, launch ? m_hold : '0);
    chk("vc_out", vc_out, m_vc);
    chk("err_credit", err_credit, m_err);
    if (iv && rdy) begin
      m_hold = id;
      m_hv   = (id[PPV_POS +: PPV_W] != '0);
    end else if (launch) begin
      m_hv = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    in_valid   = 1'b0;
    credit_ret = '0;
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_vc", vc_out, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_avail", vc_avail, 4'hf);
    chk("rst_err", err_credit, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    credit_ret = '0;
    nlaunch    = 0;
    m_reset();

    for (int i = 0; i < 7; i++) begin
      tbl[i].iv    = (i < 6);
      tbl[i].d     = (i < 6) ? mk(5'h11, i + 1) : '0;
      tbl[i].ret   = '0;
      tbl[i].e_rdy = 1'b1;
      tbl[i].e_vld = (i > 0);
      tbl[i].e_vc  = (i > 0) ? (i - 1) % 4 : 0;
      tbl[i].e_dat = (i > 0) ? mk(5'h11, i) : '0;
    end

    do_reset();

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].iv, tbl[i].d, tbl[i].ret);
      chk("rr_ready", last_rdy, tbl[i].e_rdy);
      chk("rr_valid", valid_out, tbl[i].e_vld);
      chk("rr_vc", vc_out, tbl[i].e_vc);
      chk("rr_data", data_out, tbl[i].e_dat);
    end

    do_reset();
    nlaunch = 0;
    for (int i = 0; i < 17; i++) cyc(1'b1, mk(5'h1, 100 + i), 4'h0);
    chk("exh_count", nlaunch, 16);
    cyc(1'b0, '0, 4'h0);
    chk("exh_ready", last_rdy, 0);
    chk("exh_avail", vc_avail, 4'h0);
    cyc(1'b0, '0, 4'b0100);
`ifndef OPC_TX_CREDIT_BYPASS_EN
    chk("exh_wait", valid_out, 0);
    cyc(1'b0, '0, 4'h0);
`endif
    chk("exh_valid", valid_out, 1);
    chk("exh_vc", vc_out, 2);
    chk("exh_data", data_out, mk(5'h1, 116));

    cyc(1'b1, mk(5'h3, 200), 4'h0);
    chk("stall_ready", in_ready, 0);
    do_reset();
    cyc(1'b0, '0, 4'h0);
    chk("rst_drop", valid_out, 0);

    for (int i = 0; i < 14; i++) cyc(1'b1, mk(5'h2, 300 + i), 4'h0);
    cyc(1'b0, '0, 4'b0010);
    chk("sim_valid", valid_out, 1);
    chk("sim_vc", vc_out, 1);
    chk("sim_avail1", vc_avail[1], 1);

    do_reset();
    cyc(1'b0, '0, 4'b1000);
    chk("ovf_err", err_credit, 1);
    chk("ovf_avail", vc_avail, 4'hf);
    repeat (3) cyc(1'b0, '0, 4'h0);
    chk("ovf_sticky", err_credit, 1);
    do_reset();

    cyc(1'b1, mk(5'h4, 1), 4'h0);
    cyc(1'b0, '0, 4'h0);
    chk("null_pre_vc", vc_out, 0);
    cyc(1'b1, mk(5'h0, 2), 4'h0);
    cyc(1'b0, '0, 4'h0);
    chk("null_novalid", valid_out, 0);
    cyc(1'b1, mk(5'h8, 3), 4'h0);
    cyc(1'b0, '0, 4'h0);
    chk("null_valid", valid_out, 1);
    chk("null_ptr", vc_out, 1);

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit         iv;
      flit_t      d;
      logic [3:0] r;
      iv = ($urandom_range(0, 3) != 0);
      d  = flit_t'($urandom);
      if ($urandom_range(0, 7) == 0) d[PPV_POS +: PPV_W] = '0;
      r  = 4'($urandom & $urandom & $urandom);
      cyc(iv, d, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
